ldtu_out_fifo: RTL

// Output buffer downstream of the LDTU control unit. Stores 32-bit words written by the CU (data words,

---
 rtl/ldtu_out_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/ldtu_out_fifo.sv
// Output word buffer between the LDTU control unit and the serializer.
// Registered read port, advisory almost-full flag, sticky overflow/underflow for slow control.
module ldtu_out_fifo #(
    parameter int          Nbits_32    = 32,
    parameter int          FifoDepth   = 16,
    parameter int          bits_ptr    = 4,
    parameter int          FULL_MARGIN = 2,
    parameter logic [31:0] IDLE_WORD   = 32'hEAAA_AAAA
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic                write_signal,
    input  logic [Nbits_32-1:0] DATA_from_CU,
    input  logic                read_signal,
    output logic                full,
    output logic [Nbits_32-1:0] DATA_out,
    output logic                data_valid,
    output logic [bits_ptr:0]   occupancy,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [bits_ptr:0] DEPTH_C   = (bits_ptr+1)'(FifoDepth);
    localparam logic [bits_ptr:0] FULL_TH_C = (bits_ptr+1)'(FifoDepth - FULL_MARGIN);

    logic [Nbits_32-1:0] mem [FifoDepth];
    logic [bits_ptr-1:0] wr_ptr;
    logic [bits_ptr-1:0] rd_ptr;
    logic                rd_acc;
    logic                wr_acc;
    logic [bits_ptr:0]   occ_next;

    // Strobe semantics: each cycle with write_signal=1 offers one word, stored unless the
    // buffer is truly full (a same-cycle read frees the slot); each cycle with read_signal=1
    // produces one word on DATA_out one edge later, with data_valid=0 and IDLE_WORD when empty.
    always_comb begin
        rd_acc   = read_signal && (occupancy != '0);
        wr_acc   = write_signal && ((occupancy != DEPTH_C) || rd_acc);
        occ_next = occupancy + (bits_ptr+1)'(wr_acc) - (bits_ptr+1)'(rd_acc);
    end

    // Storage is not reset; writes presented during reset are ignored.
    always_ff @(posedge CLK) begin
        if (rst_b && wr_acc) begin
            mem[wr_ptr] <= DATA_from_CU;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            full       <= 1'b0;
            DATA_out   <= IDLE_WORD[Nbits_32-1:0];
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + 1'b1;
                DATA_out   <= mem[rd_ptr];
                data_valid <= 1'b1;
            end else if (read_signal) begin
                DATA_out   <= IDLE_WORD[Nbits_32-1:0];
                data_valid <= 1'b0;
                underflow  <= 1'b1;
            end
            if (write_signal && !wr_acc) begin
                overflow <= 1'b1;
            end
            occupancy <= occ_next;
            full      <= (occ_next >= FULL_TH_C);
        end
    end

endmodule
